// File: rtl/bdd_loader_pkg.sv
// ============================================================================
// Package     : bdd_loader_pkg
// Description : Shared constants and state type for the BDD frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bdd_loader_pkg;

    localparam int IN_W      = 1894;
    localparam int WORD_W    = 32;
    localparam int NWORDS    = (IN_W + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = IN_W - (NWORDS - 1) * WORD_W;
    localparam int CNT_W     = 6;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bdd_frame_loader.sv
// ============================================================================
// Module      : bdd_frame_loader
// Description : Assembles the 1894-bit decision vector from a 32-bit stream
//               and holds it stable for the bit modules until acknowledged.
//               Optional word parity checking: BDD_FRAME_LOADER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bdd_frame_loader
    import bdd_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
`ifdef BDD_FRAME_LOADER_PARITY_EN
    input  logic                s_par,
    output logic                err_par,
    output logic                frame_bad,
`endif
    output logic [IN_W-1:0]     frame_o,
    output logic                frame_valid,
    input  logic                frame_ack,
    output logic [CNT_W-1:0]    word_cnt,
    output logic                err_len
);

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NWORDS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] w_word_cnt_nxt;
    logic             r_err_len;
    logic             w_accept;
    logic             w_at_last;
    logic             w_early_last;
    logic             w_missing_last;

    assign w_accept       = s_valid && (r_state == FILL);
    assign w_at_last      = (r_word_cnt == C_LAST_IDX);
    assign w_early_last   = w_accept && s_last && !w_at_last;
    assign w_missing_last = w_accept && !s_last && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    // The counter parks on the last index during HOLD instead of wrapping.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (w_at_last) begin
                        w_state_nxt = HOLD;
                    end else if (s_last) begin
                        w_word_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    w_state_nxt    = FILL;
                    w_word_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = FILL;
                w_word_cnt_nxt = '0;
            end
        endcase
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_slot
        localparam int C_SLOT_W = (k == NWORDS - 1) ? LAST_BITS : WORD_W;
        logic [C_SLOT_W-1:0] r_slot;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (w_accept && (r_word_cnt == CNT_W'(k))) begin
                r_slot <= s_data[C_SLOT_W-1:0];
            end
        end

        assign frame_o[k*WORD_W +: C_SLOT_W] = r_slot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len <= 1'b0;
        end else if (w_early_last || w_missing_last) begin
            r_err_len <= 1'b1;
        end
    end

`ifdef BDD_FRAME_LOADER_PARITY_EN
    logic w_par_bad;
    logic r_err_par;
    logic r_frame_bad;

    assign w_par_bad = w_accept && (s_par != (^s_data));

    // A discarded partial frame takes its parity mark with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_par   <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            if (w_par_bad) begin
                r_err_par <= 1'b1;
            end
            if ((r_state == HOLD) && frame_ack) begin
                r_frame_bad <= 1'b0;
            end else if (w_early_last) begin
                r_frame_bad <= 1'b0;
            end else if (w_par_bad) begin
                r_frame_bad <= 1'b1;
            end
        end
    end

    assign err_par   = r_err_par;
    assign frame_bad = r_frame_bad && (r_state == HOLD);
`endif

    assign s_ready     = (r_state == FILL);
    assign frame_valid = (r_state == HOLD);
    assign word_cnt    = r_word_cnt;
    assign err_len     = r_err_len;

endmodule

`default_nettype wire

// File: tb/tb_bdd_frame_loader.sv
// ============================================================================
// Module      : tb_bdd_frame_loader
// Description : Scoreboard bench for bdd_frame_loader with a frame-level
//               reference model. Honours BDD_FRAME_LOADER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bdd_frame_loader;
    import bdd_loader_pkg::*;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                s_valid   = 1'b0;
    logic                s_last    = 1'b0;
    logic                frame_ack = 1'b0;
    logic [WORD_W-1:0]   s_data    = '0;
    logic                s_ready;
    logic [IN_W-1:0]     frame_o;
    logic                frame_valid;
    logic [CNT_W-1:0]    word_cnt;
    logic                err_len;
`ifdef BDD_FRAME_LOADER_PARITY_EN
    logic                s_par     = 1'b0;
    logic                err_par;
    logic                frame_bad;
`endif

    always #5 clk = ~clk;

    bdd_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
`ifdef BDD_FRAME_LOADER_PARITY_EN
        .s_par       (s_par),
        .err_par     (err_par),
        .frame_bad   (frame_bad),
`endif
        .frame_o     (frame_o),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .word_cnt    (word_cnt),
        .err_len     (err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame contents, position, hold flag and sticky errors.
    logic [IN_W-1:0] m_frame;
    int              m_cnt;
    bit              m_hold, m_err, m_bad, m_errpar;

    typedef struct {
        logic [IN_W-1:0] frame;
        bit              err;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_frame(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        logic [NWORDS*WORD_W-1:0] a, e;
        int k;
        n_checks++;
        if (act !== exp) begin
            a = {{(NWORDS*WORD_W-IN_W){1'b0}}, act};
            e = {{(NWORDS*WORD_W-IN_W){1'b0}}, exp};
            k = 0;
            while (k < NWORDS - 1 && a[k*WORD_W +: WORD_W] === e[k*WORD_W +: WORD_W]) k++;
            n_fail++;
            $display("FAIL %s: slot %0d got %08h expected %08h (t=%0t)", name, k,
                     a[k*WORD_W +: WORD_W], e[k*WORD_W +: WORD_W], $time);
        end
    endtask

    task automatic m_reset();
        m_frame  = '0;
        m_cnt    = 0;
        m_hold   = 0;
        m_err    = 0;
        m_bad    = 0;
        m_errpar = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit valid, input logic [WORD_W-1:0] data,
                              input bit last, input bit ack, input bit bad);
        exp_t item;
        if (!m_hold) begin
            if (valid) begin
                if (m_cnt == NWORDS - 1) m_frame[IN_W-1 -: LAST_BITS] = data[LAST_BITS-1:0];
                else                     m_frame[m_cnt*WORD_W +: WORD_W] = data;
                if (bad) m_errpar = 1;
                if (m_cnt == NWORDS - 1) begin
                    m_hold = 1;
                    if (!last) m_err = 1;
                    if (bad) m_bad = 1;
                    item.frame = m_frame;
                    item.err   = m_err;
                    exp_q.push_back(item);
                end else if (last) begin
                    m_cnt = 0;
                    m_err = 1;
                    m_bad = 0;
                end else begin
                    m_cnt++;
                    if (bad) m_bad = 1;
                end
            end
        end else if (ack) begin
            m_hold = 0;
            m_cnt  = 0;
            m_bad  = 0;
        end
    endtask

    // One clock: check state left by the previous edge, then drive the next one.
    task automatic cycle(input bit valid, input logic [WORD_W-1:0] data,
                         input bit last, input bit ack, input bit bad);
        @(negedge clk);
        check("s_ready", s_ready, !m_hold);
        check("frame_valid", frame_valid, m_hold);
        check("word_cnt", word_cnt, m_cnt);
        check("err_len", err_len, m_err);
`ifdef BDD_FRAME_LOADER_PARITY_EN
        check("err_par", err_par, m_errpar);
        check("frame_bad", frame_bad, m_hold && m_bad);
        s_par     = (^data) ^ bad;
`endif
        s_valid   = valid;
        s_data    = data;
        s_last    = last;
        frame_ack = ack;
        model_step(valid, data, last, ack, bad);
    endtask

    // Monitor: pops an expected frame whenever frame_valid rises.
    initial begin : monitor
        bit   prev_fv;
        exp_t cur;
        prev_fv   = 0;
        cur.frame = '0;
        cur.err   = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_valid && !prev_fv) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: frame_valid rose with no expected frame (t=%0t)", $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check_frame("frame_o", frame_o, cur.frame);
                        check("frame_err_len", err_len, cur.err);
                    end
                end else if (frame_valid) begin
                    check_frame("frame_hold", frame_o, cur.frame);
                end
            end
            prev_fv = frame_valid;
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit v, l, a, b;
        m_reset();
        #1;
        check_frame("reset_frame", frame_o, '0);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_err_len", err_len, 0);
        check("reset_word_cnt", word_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frame: word k = k * 0x01010101.
        for (int k = 0; k < NWORDS; k++) cycle(1, k * 32'h0101_0101, k == NWORDS - 1, 0, 0);
        cycle(1, $urandom, 0, 0, 0);
        check("slot0", frame_o[31:0], 32'h0);
        check("slot1", frame_o[63:32], 32'h0101_0101);
        check("slot59", frame_o[IN_W-1 -: LAST_BITS], 6'h3B);
        check("dir_err_len", err_len, 0);
        for (int k = 0; k < 20; k++) cycle(1, $urandom, 0, 0, 0);
        check("hold_word_cnt", word_cnt, NWORDS - 1);

        cycle(0, 0, 0, 1, 0);
        cycle(1, 32'hA5A5_0001, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("after_ack_slot0", frame_o[31:0], 32'hA5A5_0001);

        // Early s_last on word 10 (word 0 already written above).
        for (int k = 1; k <= 10; k++) cycle(1, $urandom, k == 10, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("early_err_len", err_len, 1);
        check("early_word_cnt", word_cnt, 0);
        for (int k = 0; k < NWORDS; k++) cycle(1, $urandom, k == NWORDS - 1, 0, 0);
        cycle(0, 0, 0, 1, 0);

`ifdef BDD_FRAME_LOADER_PARITY_EN
        for (int k = 0; k < NWORDS; k++) cycle(1, $urandom, k == NWORDS - 1, 0, k == 5);
        cycle(0, 0, 0, 0, 0);
        check("par_frame_bad", frame_bad, 1);
        cycle(0, 0, 0, 1, 0);
        for (int k = 0; k < NWORDS; k++) cycle(1, $urandom, k == NWORDS - 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("clean_frame_bad", frame_bad, 0);
        check("clean_err_par", err_par, 1);
        cycle(0, 0, 0, 1, 0);
`endif

        // Asynchronous reset between edges while word 30 is pending.
        for (int k = 0; k <= 30; k++) cycle(1, $urandom | 32'h1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_frame("arst_frame", frame_o, '0);
        check("arst_frame_valid", frame_valid, 0);
        check("arst_err_len", err_len, 0);
        check("arst_word_cnt", word_cnt, 0);
        s_valid = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic: gaps, stray acks, early/missing s_last, parity errors.
        for (int c = 0; c < 2500; c++) begin
            v = ($urandom_range(0, 3) != 0);
            if (m_cnt == NWORDS - 1) l = ($urandom_range(0, 9) != 0);
            else                     l = ($urandom_range(0, 149) == 0);
            a = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 99) == 0);
            cycle(v, $urandom, l, a, b);
        end
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bdd_frame_loader.md
# bdd_frame_loader

Input-side loader for the generated per-bit decision modules (`module_output_bit_*`). It assembles the 1894-bit decision vector `i[1893:0]` from a 32-bit valid/ready word stream. It then holds the vector stable on `frame_o` while the combinational bit modules evaluate, and releases it on a consumer acknowledge. It is the stage directly upstream of every bit module: `frame_o` drives their `i` inputs unchanged.

## Interface
- `IN_W`, 1894: width of the assembled frame; equals the bit modules' input width.
- `WORD_W`, 32: stream word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word this cycle.
- `s_data` in `WORD_W`: stream word; word k carries frame bits `[k*WORD_W +: WORD_W]`.
- `s_last` in 1: marks the final word of a frame.
- `frame_o` out `IN_W`: assembled frame, fed to the bit modules.
- `frame_valid` out 1: `frame_o` is complete and stable.
- `frame_ack` in 1: consumer has sampled the bit-module outputs.
- `word_cnt` out 6: index of the next word to be written.
- `err_len` out 1: sticky framing error.
- Reset is asynchronous and active-low (`rst_n`); single clock `clk`.

## Operation
- Derived constants:
  - NWORDS = ceil(`IN_W`/`WORD_W`) = 60.
  - LAST_BITS = `IN_W` − (NWORDS−1)·`WORD_W` = 6. Only `s_data[5:0]` of word 59 is stored; the upper bits are ignored.
- FSM, two states:
  - FILL: `s_ready`=1. A handshake (`s_valid` & `s_ready`) writes `s_data` at slot `word_cnt`, then `word_cnt`++.
  - HOLD: `s_ready`=0 and `frame_valid`=1. `frame_o` is frozen.
- FILL → HOLD when the word at `word_cnt`=NWORDS−1 is accepted.
- HOLD → FILL on `frame_ack`; `word_cnt` returns to 0.
- Early `s_last` (handshake with `s_last`=1 and `word_cnt`<NWORDS−1):
  - the partial frame is discarded and `word_cnt` returns to 0;
  - state stays FILL and `err_len` is set;
  - already-written slots are not cleared.
- Missing `s_last` on word NWORDS−1: the frame completes normally (go to HOLD) and `err_len` is set.
- `frame_ack` in FILL is ignored.
- `err_len` clears only on reset.
- `frame_o` is not cleared between frames. Each slot is overwritten as its word arrives.
- Reset values:
  - state FILL, `word_cnt`=0;
  - `frame_o`=0, `frame_valid`=0, `err_len`=0;
  - `s_ready`=1 once `rst_n` is deasserted.
- Reset mid-frame or mid-HOLD abandons the frame immediately (asynchronous reset).

## Timing
- `s_ready` and `frame_valid` are decoded from registered state. There is no combinational path from `s_valid` or `frame_ack` to any output.
- Last word accepted on edge N: `frame_valid`=1 and `s_ready`=0 from edge N onward. The bit modules' outputs are settled one cycle later.
- `frame_ack` sampled on edge M: `frame_valid`=0 and `s_ready`=1 after edge M. A new first word can be accepted on edge M+1.
- Minimum frame period: NWORDS + 1 cycles with back-to-back `s_valid` and immediate ack.
- `word_cnt` saturates logically at NWORDS−1 and never wraps past it.

## Configuration
- Macro: `BDD_FRAME_LOADER_PARITY_EN`.
- With the macro defined:
  - Extra input `s_par` (1 bit, even parity over the full `s_data`) and extra outputs `err_par` (sticky) and `frame_bad`.
  - A mismatch on any accepted word sets `err_par` and marks the current frame: `frame_bad`=1 while that frame is in HOLD.
  - `frame_bad` clears on the transition back to FILL.
- Without the macro: none of these ports or their logic exist. All other behaviour is identical.

## Structure
- Package `bdd_loader_pkg` holds:
  - `IN_W`, `WORD_W`, NWORDS, LAST_BITS;
  - a `localparam` for the `word_cnt` width;
  - the state enum `{FILL, HOLD}`.
- No sub-module: slot write decode, FSM and error flags form one block. The bit modules are instantiated by the parent, not here.

## Test plan
- Reset, then 60 back-to-back words with word k = k·0x01010101 and `s_last` on word 59:
  - `frame_valid` rises after the 60th handshake;
  - `frame_o[31:0]`=0, `frame_o[63:32]`=0x01010101, `frame_o[1893:1888]`=0x3B & 0x3F;
  - `err_len`=0.
- Hold `frame_ack` low for 20 cycles with `s_valid`=1: `s_ready` stays 0, `frame_o` is unchanged, `word_cnt`=59.
- Pulse `frame_ack`: `s_ready`=1 on the next cycle and the next word lands in slot 0.
- `s_last` on word 10: `err_len`=1, `word_cnt`=0, `frame_valid` stays 0; the next 60 words form a valid frame.
- Assert `rst_n`=0 asynchronously at word 30: all outputs return to reset values within the same cycle.
- With `BDD_FRAME_LOADER_PARITY_EN`, bad `s_par` on word 5: `err_par`=1 and `frame_bad`=1 during HOLD; both flags are 0 for a following clean frame, except `err_par`, which stays set.
